// File: rtl/if_fetch_unit.sv
// IF stage producer: owns the PC and fetches over an imem req/ack handshake.
// It delivers registered PC/instruction pairs to IF/ID. Optional FETCH_ALIGN_CHECK_EN adds align_err.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_PC_out,
  output logic [31:0] IF_inst_out,
  output logic        IF_valid,
  output logic        flush_out,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic        align_err,
`endif
  output logic        fetch_busy
);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DROP} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_drop_addr;
  logic [31:0] r_hold_pc;
  logic [31:0] r_hold_inst;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_inst;
  logic        r_if_valid;
  logic        r_flush;

  logic        w_req;
  logic        w_ack;
  logic [31:0] w_target;
  logic [31:0] w_pc_next;

`ifdef FETCH_ALIGN_CHECK_EN
  logic        r_align_err;
  assign w_target  = {redirect_pc[31:2], 2'b00};
  assign align_err = r_align_err;
`else
  assign w_target  = redirect_pc;
`endif

  // Reset gates the request combinationally so an outstanding fetch is dropped at once.
  assign w_req     = ~Rst & (r_state != S_HOLD);
  assign w_ack     = imem_ack & w_req;
  assign w_pc_next = r_pc + PC_STEP;

  assign imem_req    = w_req;
  assign fetch_busy  = w_req;
  // In DROP the PC already holds the redirect target; memory still sees the old address.
  assign imem_addr   = (r_state == S_DROP) ? r_drop_addr : r_pc;
  assign IF_PC_out   = r_if_pc;
  assign IF_inst_out = r_if_inst;
  assign IF_valid    = r_if_valid;
  assign flush_out   = r_flush;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state     <= S_FETCH;
      r_pc        <= RESET_PC;
      r_drop_addr <= '0;
      r_hold_pc   <= '0;
      r_hold_inst <= NOP_INST;
      r_if_pc     <= '0;
      r_if_inst   <= NOP_INST;
      r_if_valid  <= 1'b0;
      r_flush     <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      r_align_err <= 1'b0;
`endif
    end else begin
      r_if_pc    <= '0;
      r_if_inst  <= NOP_INST;
      r_if_valid <= 1'b0;
      r_flush    <= 1'b0;
      if (redirect_valid) begin
        r_pc    <= w_target;
        r_flush <= 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
        if (redirect_pc[1:0] != 2'b00)
          r_align_err <= 1'b1;
`endif
        if (r_state == S_HOLD || w_ack) begin
          r_state <= S_FETCH;
        end else begin
          r_state <= S_DROP;
          if (r_state == S_FETCH)
            r_drop_addr <= r_pc;
        end
      end else begin
        case (r_state)
          S_FETCH: begin
            if (w_ack) begin
              r_pc <= w_pc_next;
              if (stall) begin
                r_hold_pc   <= r_pc;
                r_hold_inst <= imem_rdata;
                r_state     <= S_HOLD;
              end else begin
                r_if_pc    <= r_pc;
                r_if_inst  <= imem_rdata;
                r_if_valid <= 1'b1;
              end
            end
          end
          S_HOLD: begin
            if (!stall) begin
              r_if_pc    <= r_hold_pc;
              r_if_inst  <= r_hold_inst;
              r_if_valid <= 1'b1;
              r_state    <= S_FETCH;
            end
          end
          S_DROP: begin
            if (w_ack)
              r_state <= S_FETCH;
          end
          default: r_state <= S_FETCH;
        endcase
      end
    end
  end

endmodule
